// File: rtl/rfsoc_pl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rfsoc_pl_pkg
// Description : Shared constants and types for the RFSoC PL capture path.
// Revision    : 1.0 - initial release
// ============================================================================
package rfsoc_pl_pkg;

    localparam int NUM_CHANNELS  = 16;
    localparam int RF_AXIS_WIDTH = 256;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DRAIN   = 2'd2
    } capture_state_e;

endpackage
`default_nettype wire

// File: rtl/capture_buffer.sv
`default_nettype none
// ============================================================================
// Module      : capture_buffer
// Description : Simple dual-port RAM, one write port, registered read port.
// Revision    : 1.0 - initial release
// ============================================================================
module capture_buffer #(
    parameter int WIDTH = 256,
    parameter int DEPTH = 64
) (
    input  logic                     clk,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_waddr,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic                     i_re,
    input  logic [$clog2(DEPTH)-1:0] i_raddr,
    output logic [WIDTH-1:0]         o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    // A same-address read returns the beat being written, so a one-beat
    // capture can be read back in the very cycle it is stored.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            o_rdata <= (i_we && (i_waddr == i_raddr)) ? i_wdata : r_mem[i_raddr];
        end
    end

endmodule
`default_nettype wire

// File: rtl/rfsoc_adc_capture.sv
`default_nettype none
// ============================================================================
// Module      : rfsoc_adc_capture
// Description : Captures N beats from one of 16 ADC streams, drains 32-bit words.
// Revision    : 1.0 - initial release
// ============================================================================
module rfsoc_adc_capture
    import rfsoc_pl_pkg::*;
#(
    parameter int PS_AXIS_WIDTH = 32,
    parameter int BUF_DEPTH     = 64
) (
    input  logic                                  pl_clk,
    input  logic                                  rst,
    input  logic                                  start,
    input  logic [3:0]                            chan_sel,
    input  logic [$clog2(BUF_DEPTH):0]            beat_count,
    input  logic [RF_AXIS_WIDTH*NUM_CHANNELS-1:0] s_axis_tdata,
    input  logic [NUM_CHANNELS-1:0]               s_axis_tvalid,
    output logic [NUM_CHANNELS-1:0]               s_axis_tready,
    output logic [PS_AXIS_WIDTH-1:0]              m_axis_tdata,
    output logic                                  m_axis_tvalid,
    input  logic                                  m_axis_tready,
    output logic                                  m_axis_tlast,
    output logic                                  busy,
    output logic                                  done
);

    localparam int              c_AW        = $clog2(BUF_DEPTH);
    localparam int              c_PW        = c_AW + 1;
    localparam int              c_WORDS     = RF_AXIS_WIDTH / PS_AXIS_WIDTH;
    localparam int              c_WW        = $clog2(c_WORDS);
    localparam logic [c_PW-1:0] c_DEPTH     = c_PW'(BUF_DEPTH);
    localparam logic [c_PW-1:0] c_PTR_ONE   = c_PW'(1);
    localparam logic [c_WW-1:0] c_WORD_ONE  = c_WW'(1);
    localparam logic [c_WW-1:0] c_LAST_WORD = c_WW'(c_WORDS - 1);

    capture_state_e r_state;
    capture_state_e w_state_nxt;

    logic [3:0]               r_chan;
    logic [c_PW-1:0]          r_count;
    logic [c_PW-1:0]          r_wr_ptr;
    logic [c_PW-1:0]          r_rd_ptr;
    logic [c_PW-1:0]          r_beats_out;
    logic [c_WW-1:0]          r_word;
    logic                     r_pf_valid;
    logic                     r_tvalid;
    logic                     r_done;
    logic [RF_AXIS_WIDTH-1:0] r_beat;

    logic [RF_AXIS_WIDTH-1:0] w_rd_data;
    logic [RF_AXIS_WIDTH-1:0] w_sel_data;
    logic [c_PW-1:0]          w_req_count;
    logic                     w_sel_valid;
    logic                     w_accept;
    logic                     w_zero_req;
    logic                     w_wr_en;
    logic                     w_last_wr;
    logic                     w_hs;
    logic                     w_beat_done;
    logic                     w_load;
    logic                     w_rd_en;
    logic                     w_final_hs;

    assign s_axis_tready = {NUM_CHANNELS{1'b1}};

    assign w_sel_valid = s_axis_tvalid[r_chan];
    assign w_sel_data  = s_axis_tdata[32'(r_chan) * RF_AXIS_WIDTH +: RF_AXIS_WIDTH];
    assign w_req_count = (beat_count > c_DEPTH) ? c_DEPTH : beat_count;
    assign w_accept    = (r_state == ST_IDLE) && start && (beat_count != '0);
    assign w_zero_req  = (r_state == ST_IDLE) && start && (beat_count == '0);

    assign w_wr_en     = (r_state == ST_CAPTURE) && w_sel_valid;
    assign w_last_wr   = w_wr_en && ((r_wr_ptr + c_PTR_ONE) == r_count);

    assign w_hs        = r_tvalid && m_axis_tready;
    assign w_beat_done = w_hs && (r_word == c_LAST_WORD);
    assign w_final_hs  = w_beat_done && (r_beats_out == r_count);

    // r_beat is the beat being narrowed; the RAM output register holds the
    // next one.  Beat 0 is read during the final write so that DRAIN can
    // present it one cycle later, and each refill is issued as the holding
    // slot is consumed, which keeps word 7 -> word 0 bubble-free.
    assign w_load  = (r_state == ST_DRAIN) && r_pf_valid && (!r_tvalid || w_beat_done);
    assign w_rd_en = w_last_wr ||
                     ((r_state == ST_DRAIN) && (r_rd_ptr < r_count) && (!r_pf_valid || w_load));

    capture_buffer #(
        .WIDTH (RF_AXIS_WIDTH),
        .DEPTH (BUF_DEPTH)
    ) u_buffer (
        .clk     (pl_clk),
        .i_we    (w_wr_en),
        .i_waddr (r_wr_ptr[c_AW-1:0]),
        .i_wdata (w_sel_data),
        .i_re    (w_rd_en),
        .i_raddr (r_rd_ptr[c_AW-1:0]),
        .o_rdata (w_rd_data)
    );

    always_ff @(posedge pl_clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                busy = 1'b1;
                if (w_last_wr) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                busy = 1'b1;
                if (w_final_hs) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge pl_clk) begin
        if (rst) begin
            r_chan      <= '0;
            r_count     <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_beats_out <= '0;
            r_word      <= '0;
            r_pf_valid  <= 1'b0;
            r_tvalid    <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= w_zero_req || w_final_hs;
            if (w_accept) begin
                r_chan      <= chan_sel;
                r_count     <= w_req_count;
                r_wr_ptr    <= '0;
                r_rd_ptr    <= '0;
                r_beats_out <= '0;
                r_pf_valid  <= 1'b0;
            end
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_rd_en) begin
                r_rd_ptr   <= r_rd_ptr + c_PTR_ONE;
                r_pf_valid <= 1'b1;
            end else if (w_load) begin
                r_pf_valid <= 1'b0;
            end
            if (w_load) begin
                r_tvalid    <= 1'b1;
                r_beats_out <= r_beats_out + c_PTR_ONE;
            end else if (w_beat_done) begin
                r_tvalid <= 1'b0;
            end
            // Wraps 7 -> 0 at each beat boundary, so it is 0 again at packet end.
            if (w_hs) begin
                r_word <= r_word + c_WORD_ONE;
            end
        end
    end

    always_ff @(posedge pl_clk) begin
        if (w_load) begin
            r_beat <= w_rd_data;
        end
    end

    assign m_axis_tvalid = r_tvalid;
    assign m_axis_tdata  = r_tvalid ? r_beat[r_word * PS_AXIS_WIDTH +: PS_AXIS_WIDTH] : '0;
    assign m_axis_tlast  = r_tvalid && (r_word == c_LAST_WORD) && (r_beats_out == r_count);
    assign done          = r_done;

endmodule
`default_nettype wire

// File: tb/tb_rfsoc_adc_capture.sv
`default_nettype none
// ============================================================================
// Module      : tb_rfsoc_adc_capture
// Description : Scoreboard bench for rfsoc_adc_capture with directed captures.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rfsoc_adc_capture;

    logic          pl_clk = 1'b0;
    logic          rst;
    logic          start;
    logic [3:0]    chan_sel;
    logic [6:0]    beat_count;
    logic [4095:0] s_axis_tdata;
    logic [15:0]   s_axis_tvalid;
    logic [15:0]   s_axis_tready;
    logic [31:0]   m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic          m_axis_tlast;
    logic          busy;
    logic          done;

    rfsoc_adc_capture #(
        .PS_AXIS_WIDTH (32),
        .BUF_DEPTH     (64)
    ) dut (
        .pl_clk        (pl_clk),
        .rst           (rst),
        .start         (start),
        .chan_sel      (chan_sel),
        .beat_count    (beat_count),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .busy          (busy),
        .done          (done)
    );

    always #5 pl_clk = ~pl_clk;

    int          n_checks   = 0;
    int          n_fail     = 0;
    int          words_seen = 0;
    int          done_cnt   = 0;
    bit          rand_ready = 1'b0;
    logic [32:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [255:0] make_beat(input logic [15:0] id);
        logic [255:0] b;
        for (int j = 0; j < 8; j++) begin
            b[32*j +: 32] = {id, 16'(j)};
        end
        return b;
    endfunction

    function automatic logic [255:0] noise(input int ch);
        return make_beat(16'hEE00 + 16'(ch));
    endfunction

    task automatic drive_chan(input int ch, input logic v, input logic [255:0] d);
        s_axis_tdata[ch*256 +: 256] = d;
        s_axis_tvalid[ch]           = v;
    endtask

    task automatic push_beat(input logic [15:0] id, input bit last);
        for (int j = 0; j < 8; j++) begin
            exp_q.push_back({last && (j == 7), id, 16'(j)});
        end
    endtask

    // Monitor: pops the scoreboard on each handshake and checks that a stalled
    // word stays put until it is taken.
    bit          stalled = 1'b0;
    logic [31:0] held_data;
    logic        held_last;
    always @(negedge pl_clk) begin
        logic [32:0] e;
        if (rst) begin
            stalled = 1'b0;
        end else begin
            if (done) done_cnt++;
            if (stalled) begin
                check("stall_tvalid", m_axis_tvalid, 1);
                check("stall_tdata", m_axis_tdata, held_data);
                check("stall_tlast", m_axis_tlast, held_last);
            end
            if (m_axis_tvalid && m_axis_tready) begin
                words_seen++;
                check("word_expected", 64'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("tdata", m_axis_tdata, e[31:0]);
                    check("tlast", m_axis_tlast, e[32]);
                end
            end
            stalled   = m_axis_tvalid && !m_axis_tready;
            held_data = m_axis_tdata;
            held_last = m_axis_tlast;
        end
    end

    initial begin
        m_axis_tready = 1'b1;
        forever begin
            @(posedge pl_clk);
            #1;
            m_axis_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic start_req(input int chan, input int req);
        @(posedge pl_clk); #1;
        start      = 1'b1;
        chan_sel   = 4'(chan);
        beat_count = 7'(req);
        @(posedge pl_clk); #1;
        start = 1'b0;
    endtask

    task automatic feed(input int chan, input int eff, input bit gaps,
                        input bit ign_start, input logic [15:0] base);
        for (int b = 0; b < eff; b++) begin
            if (gaps && b > 0) begin
                drive_chan(chan, 1'b0, make_beat(16'hBAD0));
                @(posedge pl_clk); #1;
            end
            if (ign_start && b == 1) begin
                start      = 1'b1;
                chan_sel   = 4'd9;
                beat_count = 7'd1;
            end
            drive_chan(chan, 1'b1, make_beat(base + 16'(b)));
            push_beat(base + 16'(b), b == eff - 1);
            @(posedge pl_clk); #1;
            start = 1'b0;
        end
        // Keep the selected channel streaming junk; it must never be captured.
        drive_chan(chan, 1'b1, make_beat(16'hDEAD));
    endtask

    task automatic run_capture(input int chan, input int req, input int eff, input bit gaps,
                               input bit ign_start, input logic [15:0] base);
        int dc0;
        int ws0;
        bit got;
        dc0 = done_cnt;
        ws0 = words_seen;
        start_req(chan, req);
        check("busy_rise", busy, 1);
        feed(chan, eff, gaps, ign_start, base);
        check("tvalid_not_yet", m_axis_tvalid, 0);
        @(posedge pl_clk); #1;
        check("tvalid_rise", m_axis_tvalid, 1);
        got = 1'b0;
        for (int i = 0; i < 32 * eff + 50 && !got; i++) begin
            @(posedge pl_clk); #1;
            if (done) got = 1'b1;
        end
        check("done_seen", got, 1);
        drive_chan(chan, 1'b1, noise(chan));
        @(posedge pl_clk); #1;
        check("done_one_cycle", done, 0);
        check("busy_after", busy, 0);
        check("done_count", done_cnt - dc0, 1);
        check("word_count", words_seen - ws0, 8 * eff);
        check("queue_empty", exp_q.size(), 0);
    endtask

    initial begin
        int ws0;
        int dc0;
        rst        = 1'b1;
        start      = 1'b0;
        chan_sel   = '0;
        beat_count = '0;
        for (int ch = 0; ch < 16; ch++) drive_chan(ch, 1'b1, noise(ch));
        repeat (3) @(posedge pl_clk);
        #1;
        check("rst_tvalid", m_axis_tvalid, 0);
        check("rst_tlast", m_axis_tlast, 0);
        check("rst_tdata", m_axis_tdata, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_tready", s_axis_tready, 16'hFFFF);
        rst = 1'b0;

        run_capture(5, 2, 2, 1'b0, 1'b0, 16'h0001);     // basic
        run_capture(5, 3, 3, 1'b1, 1'b0, 16'h0011);     // input gaps
        run_capture(7, 1, 1, 1'b0, 1'b0, 16'h0021);     // single beat
        rand_ready = 1'b1;
        run_capture(2, 4, 4, 1'b0, 1'b0, 16'h0031);     // output backpressure
        rand_ready = 1'b0;

        // Zero-length request
        dc0 = done_cnt;
        start_req(5, 0);
        check("zero_done", done, 1);
        check("zero_busy", busy, 0);
        @(posedge pl_clk); #1;
        check("zero_done_clear", done, 0);
        check("zero_no_tvalid", m_axis_tvalid, 0);
        check("zero_done_count", done_cnt - dc0, 1);

        // 200 does not fit the 7-bit port; its image (72) still exceeds the depth.
        run_capture(15, 200, 64, 1'b0, 1'b0, 16'h0100);
        run_capture(3, 4, 4, 1'b0, 1'b1, 16'h0041);     // start while busy

        // Reset in the middle of a drain
        ws0 = words_seen;
        dc0 = done_cnt;
        start_req(5, 2);
        feed(5, 2, 1'b0, 1'b0, 16'h0051);
        for (int i = 0; i < 100 && (words_seen - ws0) < 5; i++) begin
            @(posedge pl_clk); #1;
        end
        check("pre_reset_words", words_seen - ws0, 5);
        rst = 1'b1;
        @(posedge pl_clk); #1;
        check("reset_tvalid", m_axis_tvalid, 0);
        check("reset_busy", busy, 0);
        rst = 1'b0;
        exp_q.delete();
        drive_chan(5, 1'b1, noise(5));
        repeat (3) @(posedge pl_clk);
        #1;
        check("post_reset_idle", m_axis_tvalid, 0);
        check("reset_no_done", done_cnt - dc0, 0);
        run_capture(0, 2, 2, 1'b0, 1'b0, 16'h0061);

        repeat (5) @(posedge pl_clk);
        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_checks);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
